// File: rtl/io_read_port_buffer_if.sv
// rtl/io_read_port_buffer_if.sv - producer/CPU-side bus bundle for the I/O read port buffer
interface io_read_port_buffer_if #(
    parameter int WORD_WIDTH      = 36,
    parameter int PORT_COUNT      = 4,
    parameter int PORT_ADDR_WIDTH = 2
);
    logic [PORT_COUNT*WORD_WIDTH-1:0] in_data;
    logic [PORT_COUNT-1:0]            in_valid;
    logic [PORT_COUNT-1:0]            in_ready;
    logic [PORT_ADDR_WIDTH-1:0]       translated_address;
    logic                             read_enable;
    logic                             read_valid;
    logic [WORD_WIDTH-1:0]            read_data;
    logic                             read_empty;
    logic [PORT_COUNT*2-1:0]          port_count;

    modport master (
        output in_data, in_valid, translated_address, read_enable,
        input  in_ready, read_valid, read_data, read_empty, port_count
    );

    modport slave (
        input  in_data, in_valid, translated_address, read_enable,
        output in_ready, read_valid, read_data, read_empty, port_count
    );
endinterface

// File: rtl/io_read_port_buffer.sv
// rtl/io_read_port_buffer.sv - bank of 2-entry read-port FIFOs popped by a 1-cycle CPU read
module io_read_port_buffer #(
    parameter int WORD_WIDTH      = 36,
    parameter int PORT_COUNT      = 4,
    parameter int PORT_ADDR_WIDTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    io_read_port_buffer_if.slave  io_bus
);
    logic [WORD_WIDTH-1:0] r_head [PORT_COUNT];
    logic [WORD_WIDTH-1:0] r_tail [PORT_COUNT];
    logic [1:0]            r_count[PORT_COUNT];

    logic [WORD_WIDTH-1:0] w_head_nx [PORT_COUNT];
    logic [WORD_WIDTH-1:0] w_tail_nx [PORT_COUNT];
    logic [1:0]            w_count_nx[PORT_COUNT];

    logic [PORT_COUNT-1:0] w_sel;
    logic [PORT_COUNT-1:0] w_push;
    logic [PORT_COUNT-1:0] w_pop;
    logic                  w_hit;
    logic [WORD_WIDTH-1:0] w_rd_word;
    logic [WORD_WIDTH-1:0] w_in_word;

    logic                  r_read_valid;
    logic                  r_read_empty;
    logic [WORD_WIDTH-1:0] r_read_data;

    // An out-of-range address selects no port, so it naturally reads as empty.
    always_comb begin
        w_sel     = '0;
        w_push    = '0;
        w_pop     = '0;
        w_hit     = 1'b0;
        w_rd_word = '0;
        w_in_word = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            w_head_nx[p]  = r_head[p];
            w_tail_nx[p]  = r_tail[p];
            w_count_nx[p] = r_count[p];
            w_in_word     = io_bus.in_data[p*WORD_WIDTH +: WORD_WIDTH];
            w_sel[p]      = (int'(io_bus.translated_address) == p);
            w_push[p]     = io_bus.in_valid[p] && (r_count[p] != 2'd2);
            w_pop[p]      = io_bus.read_enable && w_sel[p] && (r_count[p] != 2'd0);
            if (w_sel[p] && (r_count[p] != 2'd0)) begin
                w_hit     = 1'b1;
                w_rd_word = r_head[p];
            end
            case ({w_push[p], w_pop[p]})
                2'b01: begin
                    w_head_nx[p]  = r_tail[p];
                    w_count_nx[p] = r_count[p] - 2'd1;
                end
                2'b10: begin
                    if (r_count[p] == 2'd0) begin
                        w_head_nx[p] = w_in_word;
                    end else begin
                        w_tail_nx[p] = w_in_word;
                    end
                    w_count_nx[p] = r_count[p] + 2'd1;
                end
                // Push can only coincide with a pop at count 1: the new word becomes head.
                2'b11: begin
                    w_head_nx[p] = w_in_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                r_head[p]  <= '0;
                r_tail[p]  <= '0;
                r_count[p] <= 2'd0;
            end
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                r_head[p]  <= w_head_nx[p];
                r_tail[p]  <= w_tail_nx[p];
                r_count[p] <= w_count_nx[p];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_read_valid <= 1'b0;
            r_read_empty <= 1'b0;
            r_read_data  <= '0;
        end else if (io_bus.read_enable) begin
            r_read_valid <= 1'b1;
            r_read_empty <= !w_hit;
            r_read_data  <= w_hit ? w_rd_word : '0;
        end else begin
            r_read_valid <= 1'b0;
        end
    end

    always_comb begin
        io_bus.in_ready   = '0;
        io_bus.port_count = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            io_bus.in_ready[p]          = (r_count[p] != 2'd2);
            io_bus.port_count[p*2 +: 2] = r_count[p];
        end
    end

    assign io_bus.read_valid = r_read_valid;
    assign io_bus.read_empty = r_read_empty;
    assign io_bus.read_data  = r_read_data;
endmodule

// File: tb/tb_io_read_port_buffer.sv
// tb/tb_io_read_port_buffer.sv - directed and scoreboarded bench for io_read_port_buffer
module tb_io_read_port_buffer;
    localparam int W = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_read_port_buffer_if #(.WORD_WIDTH(W), .PORT_COUNT(4), .PORT_ADDR_WIDTH(2)) b4();
    io_read_port_buffer_if #(.WORD_WIDTH(W), .PORT_COUNT(3), .PORT_ADDR_WIDTH(2)) b3();

    io_read_port_buffer #(.WORD_WIDTH(W), .PORT_COUNT(4), .PORT_ADDR_WIDTH(2)) dut4 (
        .i_clock(clk), .i_reset(rst), .io_bus(b4.slave)
    );
    io_read_port_buffer #(.WORD_WIDTH(W), .PORT_COUNT(3), .PORT_ADDR_WIDTH(2)) dut3 (
        .i_clock(clk), .i_reset(rst), .io_bus(b3.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] mq [4][$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b4.in_valid = '0; b4.in_data = '0; b4.read_enable = 1'b0; b4.translated_address = '0;
        b3.in_valid = '0; b3.in_data = '0; b3.read_enable = 1'b0; b3.translated_address = '0;
    endtask

    task automatic read4(input logic [1:0] a);
        b4.in_valid = '0; b4.read_enable = 1'b1; b4.translated_address = a;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if (b4.port_count !== 8'h00) begin failures++; $display("FAIL rst_count got=%h exp=00", b4.port_count); end
        checks++; if (b4.in_ready !== 4'hf) begin failures++; $display("FAIL rst_ready got=%b exp=1111", b4.in_ready); end
        checks++; if ({b4.read_valid, b4.read_empty} !== 2'b00 || b4.read_data !== '0) begin
            failures++; $display("FAIL rst_read got=v%b e%b d%h exp=v0 e0 d0", b4.read_valid, b4.read_empty, b4.read_data); end
        rst = 1'b0;
        b4.in_valid = 4'b0001; b4.in_data[W-1:0] = 36'h1; tick();
        b4.in_data[W-1:0] = 36'h2; tick();
        checks++; if (b4.port_count !== 8'h02) begin failures++; $display("FAIL mid_fill got=%h exp=02", b4.port_count); end
        read4(2'd0);
        checks++; if (b4.read_valid !== 1'b1 || b4.read_data !== 36'h1) begin
            failures++; $display("FAIL mid_read got=v%b d%h exp=v1 d1", b4.read_valid, b4.read_data); end
        #3 rst = 1'b1;
        #1;
        checks++; if (b4.port_count !== 8'h00 || b4.read_valid !== 1'b0 || b4.in_ready !== 4'hf) begin
            failures++; $display("FAIL mid_rst got=c%h v%b r%b exp=c00 v0 r1111", b4.port_count, b4.read_valid, b4.in_ready); end
        tick();
        checks++; if (b4.read_valid !== 1'b0 || b4.read_data !== '0) begin
            failures++; $display("FAIL mid_rst_hold got=v%b d%h exp=v0 d0", b4.read_valid, b4.read_data); end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain;
        b4.in_valid = 4'b0100; b4.in_data = '0;
        b4.in_data[2*W +: W] = 36'hA5; tick();
        b4.in_data[2*W +: W] = 36'h5A; tick();
        checks++; if (b4.port_count !== 8'h20 || b4.in_ready !== 4'b1011) begin
            failures++; $display("FAIL fill_full got=c%h r%b exp=c20 r1011", b4.port_count, b4.in_ready); end
        b4.in_data[2*W +: W] = 36'h77; tick();
        checks++; if (b4.port_count !== 8'h20) begin failures++; $display("FAIL fill_overflow got=%h exp=20", b4.port_count); end
        read4(2'd2);
        checks++; if (b4.read_valid !== 1'b1 || b4.read_empty !== 1'b0 || b4.read_data !== 36'hA5) begin
            failures++; $display("FAIL drain0 got=v%b e%b d%h exp=v1 e0 dA5", b4.read_valid, b4.read_empty, b4.read_data); end
        checks++; if (b4.port_count !== 8'h10 || b4.in_ready !== 4'hf) begin
            failures++; $display("FAIL drain0_state got=c%h r%b exp=c10 r1111", b4.port_count, b4.in_ready); end
        read4(2'd2);
        checks++; if (b4.read_data !== 36'h5A || b4.read_empty !== 1'b0 || b4.port_count !== 8'h00) begin
            failures++; $display("FAIL drain1 got=d%h e%b c%h exp=d5A e0 c00", b4.read_data, b4.read_empty, b4.port_count); end
        idle_inputs(); tick();
        checks++; if (b4.read_valid !== 1'b0 || b4.read_data !== 36'h5A || b4.read_empty !== 1'b0) begin
            failures++; $display("FAIL hold got=v%b d%h e%b exp=v0 d5A e0", b4.read_valid, b4.read_data, b4.read_empty); end
    endtask

    task automatic test_empty_read;
        read4(2'd1);
        checks++; if (b4.read_valid !== 1'b1 || b4.read_empty !== 1'b1 || b4.read_data !== '0 || b4.port_count !== 8'h00) begin
            failures++; $display("FAIL empty_read got=v%b e%b d%h c%h exp=v1 e1 d0 c00",
                                 b4.read_valid, b4.read_empty, b4.read_data, b4.port_count); end
        idle_inputs(); tick();
    endtask

    task automatic test_same_edge;
        b4.in_valid = 4'b1000; b4.in_data = '0; b4.in_data[3*W +: W] = 36'h11; tick();
        checks++; if (b4.port_count !== 8'h40) begin failures++; $display("FAIL se_fill got=%h exp=40", b4.port_count); end
        b4.in_data[3*W +: W] = 36'h22; b4.read_enable = 1'b1; b4.translated_address = 2'd3; tick();
        checks++; if (b4.read_data !== 36'h11 || b4.read_empty !== 1'b0 || b4.port_count !== 8'h40) begin
            failures++; $display("FAIL se_c1 got=d%h e%b c%h exp=d11 e0 c40", b4.read_data, b4.read_empty, b4.port_count); end
        read4(2'd3);
        checks++; if (b4.read_data !== 36'h22 || b4.port_count !== 8'h00) begin
            failures++; $display("FAIL se_c1_next got=d%h c%h exp=d22 c00", b4.read_data, b4.port_count); end
        b4.in_valid = 4'b0001; b4.in_data = '0; b4.in_data[W-1:0] = 36'h33;
        b4.read_enable = 1'b1; b4.translated_address = 2'd0; tick();
        checks++; if (b4.read_empty !== 1'b1 || b4.read_data !== '0 || b4.port_count !== 8'h01) begin
            failures++; $display("FAIL se_c0 got=e%b d%h c%h exp=e1 d0 c01", b4.read_empty, b4.read_data, b4.port_count); end
        read4(2'd0);
        checks++; if (b4.read_data !== 36'h33 || b4.read_empty !== 1'b0) begin
            failures++; $display("FAIL se_c0_next got=d%h e%b exp=d33 e0", b4.read_data, b4.read_empty); end
        idle_inputs(); tick();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_d [4];
        logic [1:0]   seq   [4];
        exp_d[0] = 36'h100; exp_d[1] = 36'h200; exp_d[2] = 36'h101; exp_d[3] = 36'h201;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd0; seq[3] = 2'd1;
        for (int c = 0; c < 2; c++) begin
            b4.in_valid = 4'b0011; b4.in_data = '0;
            b4.in_data[0 +: W] = 36'h100 + 36'(c);
            b4.in_data[W +: W] = 36'h200 + 36'(c);
            b4.read_enable = 1'b1; b4.translated_address = 2'd3;
            tick();
            checks++; if (b4.read_empty !== 1'b1 || b4.read_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_push%0d got=v%b e%b exp=v1 e1", c, b4.read_valid, b4.read_empty); end
        end
        checks++; if (b4.port_count !== 8'h0A) begin failures++; $display("FAIL b2b_fill got=%h exp=0a", b4.port_count); end
        for (int i = 0; i < 4; i++) begin
            read4(seq[i]);
            checks++; if (b4.read_valid !== 1'b1 || b4.read_empty !== 1'b0 || b4.read_data !== exp_d[i]) begin
                failures++; $display("FAIL b2b_read%0d got=v%b e%b d%h exp=v1 e0 d%h",
                                     i, b4.read_valid, b4.read_empty, b4.read_data, exp_d[i]); end
        end
        checks++; if (b4.port_count !== 8'h00) begin failures++; $display("FAIL b2b_drain got=%h exp=00", b4.port_count); end
        idle_inputs(); tick();
    endtask

    task automatic test_out_of_range;
        b3.in_valid = 3'b111;
        b3.in_data[0 +: W] = 36'h31; b3.in_data[W +: W] = 36'h32; b3.in_data[2*W +: W] = 36'h33;
        tick();
        checks++; if (b3.port_count !== 6'b010101) begin failures++; $display("FAIL oor_fill got=%b exp=010101", b3.port_count); end
        b3.in_valid = '0; b3.read_enable = 1'b1; b3.translated_address = 2'd3; tick();
        checks++; if (b3.read_valid !== 1'b1 || b3.read_empty !== 1'b1 || b3.read_data !== '0 || b3.port_count !== 6'b010101) begin
            failures++; $display("FAIL oor_read got=v%b e%b d%h c%b exp=v1 e1 d0 c010101",
                                 b3.read_valid, b3.read_empty, b3.read_data, b3.port_count); end
        b3.translated_address = 2'd2; tick();
        checks++; if (b3.read_data !== 36'h33 || b3.read_empty !== 1'b0 || b3.port_count !== 6'b000101) begin
            failures++; $display("FAIL oor_inrange got=d%h e%b c%b exp=d33 e0 c000101", b3.read_data, b3.read_empty, b3.port_count); end
        idle_inputs(); tick();
    endtask

    task automatic test_random;
        logic [3:0]   rdy_exp;
        logic [7:0]   pc_exp;
        logic [W-1:0] exp_data;
        logic         exp_empty;
        logic         re;
        logic [1:0]   a;
        logic [3:0]   vld;
        for (int p = 0; p < 4; p++) mq[p].delete();
        rst = 1'b1; idle_inputs(); tick(); rst = 1'b0; tick();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            vld = 4'($urandom_range(0, 15));
            re  = ($urandom_range(0, 9) < 6);
            a   = 2'($urandom_range(0, 3));
            b4.in_valid = vld; b4.read_enable = re; b4.translated_address = a;
            for (int p = 0; p < 4; p++) b4.in_data[p*W +: W] = 36'({$urandom(), $urandom()});
            for (int p = 0; p < 4; p++) begin
                rdy_exp[p] = (mq[p].size() < 2);
                pc_exp[p*2 +: 2] = 2'(mq[p].size());
            end
            #1;
            checks++; if (b4.in_ready !== rdy_exp || b4.port_count !== pc_exp) begin
                failures++; $display("FAIL rnd_state cyc=%0d got=r%b c%h exp=r%b c%h", cyc, b4.in_ready, b4.port_count, rdy_exp, pc_exp); end
            exp_data = '0; exp_empty = 1'b1;
            if (re && mq[a].size() > 0) begin
                exp_data = mq[a].pop_front(); exp_empty = 1'b0;
            end
            for (int p = 0; p < 4; p++)
                if (vld[p] && rdy_exp[p]) mq[p].push_back(b4.in_data[p*W +: W]);
            tick();
            checks++; if (b4.read_valid !== re) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, b4.read_valid, re); end
            if (re) begin
                checks++; if (b4.read_empty !== exp_empty || b4.read_data !== exp_data) begin
                    failures++; $display("FAIL rnd_read cyc=%0d port=%0d got=e%b d%h exp=e%b d%h",
                                         cyc, a, b4.read_empty, b4.read_data, exp_empty, exp_data); end
            end
        end
        idle_inputs(); tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_empty_read();
        test_same_edge();
        test_back_to_back();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
